// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage and its
// neighbours (instruction memory geometry, reset PC, FSM encoding).
package inst_fetch_unit_pkg;

  localparam int IM_ADDR_W = 7;
  localparam int INST_W    = 32;

  // Word 0 is never part of the program image, so execution starts at 1.
  localparam logic [IM_ADDR_W-1:0] DEFAULT_RESET_PC = 7'd1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus: word address / instruction toward instruction memory and
// the valid/ready instruction handshake toward decode.
interface inst_fetch_unit_if
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_W
) ();

  logic [ADDR_W-1:0] Pro_count;
  logic [INST_W-1:0] inst_in;
  logic              if_valid;
  logic              if_ready;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    output Pro_count,
    input  inst_in,
    output if_valid,
    input  if_ready,
    output if_inst,
    output if_pc
  );

  modport slave (
    input  Pro_count,
    output inst_in,
    input  if_valid,
    output if_ready,
    input  if_inst,
    input  if_pc
  );

endinterface

// File: rtl/inst_fetch_unit_if_out_reg.sv
// One-entry valid/ready register stage with load, accept and flush controls;
// flush wins over load, load wins over accept (sustains one item per cycle).
module if_out_reg #(
  parameter int DATA_W = 39
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              accept,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid
);

  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;

  // ---- stage p1: held entry ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= 1'b1;
    end else if (accept) begin
      vld_p1 <= 1'b0;
    end
  end

  // Data is only written on load; flush just invalidates the entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_p1 <= '0;
    end else if (load && !flush) begin
      data_p1 <= data_in;
    end
  end

  assign data_out = data_p1;
  assign valid    = vld_p1;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction memory and registers each fetched word toward decode.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = IM_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  inst_fetch_unit_if.master  bus,
  output logic               wrap_flag,
  output logic [CNT_W-1:0]   fetch_cnt
);

  localparam int OUT_W = INST_W + ADDR_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              wrap_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              capture;
  logic              accept;
  logic              vld_p1;
  logic [OUT_W-1:0]  out_p1;

  // Redirect freezes the state; run only gates transitions otherwise.
  always_comb begin
    state_d = state_q;
    if (!redirect_valid) begin
      unique case (state_q)
        IDLE:    if (run)  state_d = RUN;
        RUN:     if (!run) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  assign capture = (state_q == RUN) && run && (!vld_p1 || bus.if_ready)
                   && !redirect_valid;
  assign accept  = vld_p1 && bus.if_ready;

  // ---- stage p0: program counter, wrap and fetch count ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q   <= RESET_PC;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (redirect_valid) begin
        pc_q <= redirect_addr;
      end else if (capture) begin
        pc_q <= pc_q + 1'b1;
        if (&pc_q) wrap_q <= 1'b1;
      end
      if (capture) cnt_q <= sat_inc(cnt_q);
    end
  end

  // ---- stage p1: registered instruction toward decode ----
  if_out_reg #(
    .DATA_W (OUT_W)
  ) u_out_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (capture),
    .accept   (accept),
    .flush    (redirect_valid),
    .data_in  ({pc_q, bus.inst_in}),
    .data_out (out_p1),
    .valid    (vld_p1)
  );

  assign bus.Pro_count = pc_q;
  assign bus.if_valid  = vld_p1;
  assign bus.if_inst   = out_p1[INST_W-1:0];
  assign bus.if_pc     = out_p1[OUT_W-1:INST_W];
  assign wrap_flag     = wrap_q;
  assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: sequential fetch, stall, redirect,
// wrap, run gating, async reset and counter saturation (CNT_W = 2 instance).
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic        redirect_valid;
  logic [6:0]  redirect_addr;
  logic        wrap_flag, wrap_flag_s;
  logic [15:0] fetch_cnt;
  logic [1:0]  fetch_cnt_s;
  logic [31:0] mem [128];

  int checks;
  int fails;

  inst_fetch_unit_if #(.ADDR_W(7)) bus  ();
  inst_fetch_unit_if #(.ADDR_W(7)) bus2 ();

  assign bus.inst_in  = mem[bus.Pro_count];
  assign bus2.inst_in = mem[bus2.Pro_count];
  assign bus2.if_ready = bus.if_ready;

  inst_fetch_unit #(.ADDR_W(7), .RESET_PC(7'd1), .CNT_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (bus),
    .wrap_flag      (wrap_flag),
    .fetch_cnt      (fetch_cnt)
  );

  inst_fetch_unit #(.ADDR_W(7), .RESET_PC(7'd1), .CNT_W(2)) u_sat (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .bus            (bus2),
    .wrap_flag      (wrap_flag_s),
    .fetch_cnt      (fetch_cnt_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    run = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    bus.if_ready = 1'b0;
    step();
    step();
    checks++; if (bus.Pro_count !== 7'd1) begin fails++; $display("FAIL reset_pc: got %0d want 1", bus.Pro_count); end
    checks++; if (bus.if_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.if_valid); end
    checks++; if (bus.if_inst !== 32'h0 || bus.if_pc !== 7'd0) begin fails++; $display("FAIL reset_out: got %h/%0d want 0/0", bus.if_inst, bus.if_pc); end
    checks++; if (wrap_flag !== 1'b0 || fetch_cnt !== 16'd0) begin fails++; $display("FAIL reset_wrap_cnt: got %b/%0d want 0/0", wrap_flag, fetch_cnt); end
    reset_n = 1'b1;
  endtask

  task automatic test_sequence();
    run = 1'b1;
    bus.if_ready = 1'b1;
    step();  // IDLE -> RUN, no capture
    checks++; if (bus.if_valid !== 1'b0 || bus.Pro_count !== 7'd1) begin fails++; $display("FAIL seq_transition: got v=%b pc=%0d want v=0 pc=1", bus.if_valid, bus.Pro_count); end
    step();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h00430820 || bus.if_pc !== 7'd1 || bus.Pro_count !== 7'd2) begin fails++; $display("FAIL seq_first: got v=%b %h pc=%0d Pro=%0d want 1 00430820 1 2", bus.if_valid, bus.if_inst, bus.if_pc, bus.Pro_count); end
    step();
    checks++; if (bus.if_inst !== 32'h00851022 || bus.if_pc !== 7'd2 || bus.Pro_count !== 7'd3 || fetch_cnt !== 16'd2) begin fails++; $display("FAIL seq_second: got %h pc=%0d Pro=%0d cnt=%0d want 00851022 2 3 2", bus.if_inst, bus.if_pc, bus.Pro_count, fetch_cnt); end
  endtask

  task automatic test_stall();
    bus.if_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.if_valid !== 1'b1 || bus.if_inst !== 32'h00851022 || bus.if_pc !== 7'd2 || bus.Pro_count !== 7'd3) begin fails++; $display("FAIL stall_hold[%0d]: got v=%b %h pc=%0d Pro=%0d want 1 00851022 2 3", i, bus.if_valid, bus.if_inst, bus.if_pc, bus.Pro_count); end
    end
    bus.if_ready = 1'b1;
    step();
    checks++; if (bus.if_inst !== 32'h3C071064 || bus.if_pc !== 7'd3 || bus.Pro_count !== 7'd4 || fetch_cnt !== 16'd3) begin fails++; $display("FAIL stall_release: got %h pc=%0d Pro=%0d cnt=%0d want 3C071064 3 4 3", bus.if_inst, bus.if_pc, bus.Pro_count, fetch_cnt); end
  endtask

  task automatic test_redirect();
    bus.if_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 7'd40;
    step();
    redirect_valid = 1'b0;
    checks++; if (bus.if_valid !== 1'b0 || bus.Pro_count !== 7'd40) begin fails++; $display("FAIL redirect_flush: got v=%b Pro=%0d want 0 40", bus.if_valid, bus.Pro_count); end
    step();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 7'd40 || bus.if_inst !== 32'hC0DE0028 || bus.Pro_count !== 7'd41 || fetch_cnt !== 16'd4) begin fails++; $display("FAIL redirect_resume: got v=%b pc=%0d %h Pro=%0d cnt=%0d want 1 40 C0DE0028 41 4", bus.if_valid, bus.if_pc, bus.if_inst, bus.Pro_count, fetch_cnt); end
  endtask

  task automatic test_wrap();
    bus.if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 7'd127;
    step();
    redirect_valid = 1'b0;
    checks++; if (bus.Pro_count !== 7'd127 || wrap_flag !== 1'b0 || bus.if_valid !== 1'b0) begin fails++; $display("FAIL wrap_redirect127: got Pro=%0d wrap=%b v=%b want 127 0 0", bus.Pro_count, wrap_flag, bus.if_valid); end
    step();
    checks++; if (bus.if_pc !== 7'd127 || bus.Pro_count !== 7'd0 || wrap_flag !== 1'b1 || fetch_cnt !== 16'd5) begin fails++; $display("FAIL wrap_increment: got pc=%0d Pro=%0d wrap=%b cnt=%0d want 127 0 1 5", bus.if_pc, bus.Pro_count, wrap_flag, fetch_cnt); end
    redirect_valid = 1'b1;
    redirect_addr = 7'd5;
    step();
    redirect_valid = 1'b0;
    checks++; if (bus.Pro_count !== 7'd5 || wrap_flag !== 1'b1 || bus.if_valid !== 1'b0) begin fails++; $display("FAIL wrap_sticky: got Pro=%0d wrap=%b v=%b want 5 1 0", bus.Pro_count, wrap_flag, bus.if_valid); end
  endtask

  task automatic test_run_gating();
    bus.if_ready = 1'b0;
    step();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 7'd5 || bus.Pro_count !== 7'd6 || fetch_cnt !== 16'd6) begin fails++; $display("FAIL gate_capture: got v=%b pc=%0d Pro=%0d cnt=%0d want 1 5 6 6", bus.if_valid, bus.if_pc, bus.Pro_count, fetch_cnt); end
    run = 1'b0;
    step();
    step();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 7'd5 || bus.Pro_count !== 7'd6) begin fails++; $display("FAIL gate_held: got v=%b pc=%0d Pro=%0d want 1 5 6", bus.if_valid, bus.if_pc, bus.Pro_count); end
    bus.if_ready = 1'b1;
    step();
    checks++; if (bus.if_valid !== 1'b0 || bus.Pro_count !== 7'd6 || fetch_cnt !== 16'd6) begin fails++; $display("FAIL gate_accept: got v=%b Pro=%0d cnt=%0d want 0 6 6", bus.if_valid, bus.Pro_count, fetch_cnt); end
    step();
    checks++; if (bus.if_valid !== 1'b0 || bus.Pro_count !== 7'd6 || fetch_cnt !== 16'd6) begin fails++; $display("FAIL gate_stopped: got v=%b Pro=%0d cnt=%0d want 0 6 6", bus.if_valid, bus.Pro_count, fetch_cnt); end
    redirect_valid = 1'b1;
    redirect_addr = 7'd10;
    step();
    redirect_valid = 1'b0;
    checks++; if (bus.Pro_count !== 7'd10 || bus.if_valid !== 1'b0) begin fails++; $display("FAIL gate_idle_redirect: got Pro=%0d v=%b want 10 0", bus.Pro_count, bus.if_valid); end
    run = 1'b1;
    step();
    checks++; if (bus.if_valid !== 1'b0 || bus.Pro_count !== 7'd10) begin fails++; $display("FAIL gate_rerun_transition: got v=%b Pro=%0d want 0 10", bus.if_valid, bus.Pro_count); end
    step();
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 7'd10 || bus.if_inst !== 32'hC0DE000A || fetch_cnt !== 16'd7) begin fails++; $display("FAIL gate_rerun_capture: got v=%b pc=%0d %h cnt=%0d want 1 10 C0DE000A 7", bus.if_valid, bus.if_pc, bus.if_inst, fetch_cnt); end
  endtask

  task automatic test_async_reset();
    bus.if_ready = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b0 || bus.Pro_count !== 7'd1 || fetch_cnt !== 16'd0 || wrap_flag !== 1'b0) begin fails++; $display("FAIL async_reset: got v=%b Pro=%0d cnt=%0d wrap=%b want 0 1 0 0", bus.if_valid, bus.Pro_count, fetch_cnt, wrap_flag); end
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_saturation();
    run = 1'b1;
    bus.if_ready = 1'b1;
    step();  // IDLE -> RUN
    step();
    step();
    checks++; if (fetch_cnt_s !== 2'd2 || fetch_cnt !== 16'd2) begin fails++; $display("FAIL sat_two: got %0d/%0d want 2/2", fetch_cnt_s, fetch_cnt); end
    step();
    step();
    step();
    checks++; if (fetch_cnt_s !== 2'd3 || fetch_cnt !== 16'd5) begin fails++; $display("FAIL sat_five: got %0d/%0d want 3/5", fetch_cnt_s, fetch_cnt); end
    checks++; if (bus2.if_pc !== 7'd5 || bus2.Pro_count !== 7'd6) begin fails++; $display("FAIL sat_pc: got pc=%0d Pro=%0d want 5 6", bus2.if_pc, bus2.Pro_count); end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE0000 + i;
    mem[1] = 32'h00430820;
    mem[2] = 32'h00851022;
    mem[3] = 32'h3C071064;
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_wrap();
    test_run_gating();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage that owns the program counter and drives the word address into the single-cycle instruction memory.
- Registers the returned 32-bit instruction plus its PC into a one-entry output stage toward decode, using a valid/ready handshake.
- Supports redirect (branch/jump) with flush, a run/stop control, and a fetched-instruction counter.
- Sits between the instruction memory (combinational read, 128 x 32-bit words, word-indexed) and the decode stage.

Parameters:
- ADDR_W, 7, word-address width driven to instruction memory (128 words).
- RESET_PC, 7'd1, PC value loaded on reset; address 0 is unused by the program image.
- CNT_W, 16, width of the saturating fetched-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = fetching permitted; 0 = no new captures.
- Pro_count  out  ADDR_W  word address to instruction memory; equals the pc register.
- inst_in  in  32  instruction from memory at Pro_count, valid in the same cycle (combinational read).
- redirect_valid  in  1  one-cycle pulse: branch or jump taken.
- redirect_addr  in  ADDR_W  new fetch address when redirect_valid = 1.
- if_valid  out  1  output stage holds an instruction.
- if_ready  in  1  decode accepts the instruction this cycle.
- if_inst  out  32  registered instruction.
- if_pc  out  ADDR_W  address if_inst was fetched from.
- wrap_flag  out  1  sticky; set when PC increments from 2^ADDR_W-1 to 0.
- fetch_cnt  out  CNT_W  count of instructions captured; saturates at all-ones.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - pc = RESET_PC, state = IDLE, if_valid = 0, if_inst = 0, if_pc = 0, wrap_flag = 0, fetch_cnt = 0.
- States: IDLE, RUN.
  - IDLE → RUN when run = 1. No capture happens in the transition cycle.
  - RUN → IDLE when run = 0.
- Capture condition: state == RUN && run && (!if_valid || if_ready) && !redirect_valid.
- On capture (at the clock edge):
  - if_inst <= inst_in, if_pc <= pc, if_valid <= 1.
  - pc <= pc + 1, mod 2^ADDR_W.
  - fetch_cnt increments unless it is saturated.
- Output acceptance:
  - If if_valid && if_ready and there is no capture, if_valid <= 0.
  - If both happen in the same cycle, the new instruction replaces the old one. This sustains one instruction per cycle.
- Stall: if_valid && !if_ready → if_inst, if_pc and pc all hold. Pro_count stays stable.
- Latency: address to if_valid is 1 cycle.
- First instruction after run rises in IDLE:
  - Cycle N: run rises; transition to RUN.
  - Cycle N+1: capture at pc = RESET_PC.
  - Cycle N+2: if_valid visible.
- Redirect (any state, highest priority):
  - pc <= redirect_addr, if_valid <= 0 (flush, even if unaccepted), no capture that cycle.
  - State is unchanged.
  - In RUN, fetch resumes at redirect_addr the next cycle, giving one bubble.
  - In IDLE, the new pc is used when run next rises.
- run deasserted: no new captures. A valid held instruction stays until accepted or flushed.
- Wrap: pc = 2^ADDR_W-1 plus capture → pc = 0 and wrap_flag <= 1 (sticky until reset). Fetch continues.
- Redirect to 2^ADDR_W-1 does not set wrap_flag. Only the increment does.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately. if_valid drops asynchronously.

Decomposition:
- Shared package holds:
  - IM_ADDR_W = 7
  - INST_W = 32
  - RESET_PC constant
  - state enum {IDLE, RUN}
- One sub-module is natural: if_out_reg, the valid/ready one-entry register stage (load, accept, flush inputs), reusable by later pipeline stages.
- PC and FSM logic live in the top module.

Test Plan:
- Reset, run = 1, if_ready = 1; memory words 1..3 = 00430820, 00851022, 3C071064:
  - Pro_count sequence 1, 2, 3, 4.
  - if_inst sequence 00430820, 00851022, 3C071064 on consecutive cycles, with if_pc 1, 2, 3.
  - fetch_cnt = 3 after the third capture.
- Stall: if_ready = 0 with if_inst = 00851022 held for 4 cycles:
  - if_inst, if_pc = 2 and Pro_count = 3 are all stable.
  - Raise if_ready: next if_inst = 3C071064, with no duplicate or skipped instruction.
- Redirect: redirect_valid pulse with redirect_addr = 7'd40 while if_valid = 1 and if_ready = 0:
  - Next cycle if_valid = 0 and Pro_count = 40.
  - The cycle after, if_pc = 40.
- Wrap: redirect to 127, run:
  - Capture at pc 127, then Pro_count = 0 and wrap_flag = 1.
  - wrap_flag stays 1 after a further redirect to 5.
- Run gating and reset: drop run mid-stream → captures stop and the held instruction is still accepted once; assert reset_n = 0 asynchronously mid-cycle → if_valid = 0, Pro_count = 1, fetch_cnt = 0 before the next edge.
- Counter saturation: with CNT_W overridden to 2, perform 5 captures → fetch_cnt = 3.
